cp0_ctrl: RTL and testbench
===========================

Name: cp0_ctrl

Overview:
- Coprocessor 0 for the multi-cycle MIPS core.
- Sits directly downstream of the CPU's cp0 control outputs and feeds back read data, Status and the exception/return address.
- Holds Status, Cause and EPC, and optionally Count/Compare.
- Performs the Status shift-stack on exception entry and eret.

Parameters:
EXC_VECTOR, 32'h0000_0004, handler address driven on exc_addr when exception is asserted
STATUS_RESET, 32'h0000_000F, Status value after reset (IE plus all three exception masks set)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mfc0  input  1  read request for register rd
mtc0  input  1  write wdata into register rd at clock edge
pc  input  32  return address captured into EPC on accepted exception
rd  input  5  CP0 register index
wdata  input  32  mtc0 write data
exception  input  1  exception request, single-cycle pulse
eret  input  1  exception return, single-cycle pulse
cause  input  5  exception code: 8 syscall, 9 break, 13 teq
rdata  output  32  register read data
status  output  32  current Status register
exc_addr  output  32  next PC for exception entry or eret
timer_irq  output  1  timer interrupt request

Behaviour:
- Implemented registers (index):
  - Count 9 (CP0_TIMER_EN builds only)
  - Compare 11 (CP0_TIMER_EN builds only)
  - Status 12, Cause 13, EPC 14
  - All other indices: read 0, writes ignored.
- Reset (reset=1 at edge):
  - Status=STATUS_RESET; Cause, EPC, Count, Compare = 0.
  - Pending timer bit cleared.
  - Overrides every concurrent request, including reset arriving mid-exception.
- rdata:
  - Combinational: value of register rd when mfc0=1, else 32'h0.
  - A same-cycle mtc0 to the same register is not forwarded; rdata shows the pre-edge value.
- status output: always the registered Status value.
- exc_addr:
  - Combinational: EPC when eret=1 and exception=0, else EXC_VECTOR.
  - Zero latency; the CPU loads PC in the same cycle.
- Exception acceptance: exception=1 and Status[0]=1 and the mask bit for the code is set.
  - Mask bits: syscall→Status[1], break→Status[2], teq→Status[3].
  - Any other code is accepted on Status[0] alone.
- Accepted exception, at the edge:
  - EPC<=pc.
  - Cause[6:2]<=cause, other Cause bits kept.
  - Status<={Status[26:0],5'b0} (old IE/mask group pushed, new group zero, disabling nesting).
- Rejected exception: no state change; exc_addr still EXC_VECTOR.
- eret, at the edge: Status<={5'b0,Status[31:5]}. EPC and Cause unchanged.
- Simultaneous events:
  - exception and eret together: exception wins, eret ignored.
  - Accepted exception together with mtc0 to Status, Cause or EPC: the exception update wins for that register.
  - mtc0 to any other register still takes effect in that cycle.
  - eret together with mtc0 to Status: eret wins.
- mtc0 to Cause writes only bits [9:8] (software IP); all other Cause bits are read-only.
- Without CP0_TIMER_EN, timer_irq is constant 0.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined:
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF→0.
  - mtc0 to Count loads wdata; that cycle's increment is suppressed.
  - mtc0 to Compare loads wdata and clears Cause[15].
  - When Count==Compare and Compare!=0, Cause[15] is set at the next edge and stays set until a Compare write or reset.
  - timer_irq = Cause[15] & Status[15] & Status[0], registered-state based, no combinational path from inputs.
  - Status[15] is writable by mtc0 and participates in the shift-stack like all other bits.
- Undefined: no Count/Compare storage; indices 9 and 11 read 0; Cause[15] stays 0; timer_irq=0.

Test Plan:
1. Reset, then mfc0 rd=12 -> rdata=32'h0000_000F. Then mfc0 rd=13 and rd=14 -> 0; timer_irq=0.
2. Status=0x0F, pulse exception cause=8 pc=32'h0040_0010 -> exc_addr=32'h4 that cycle. Next cycle: EPC=0x0040_0010, Cause=32'h20, Status=32'h0000_01E0.
3. After test 2, pulse eret -> exc_addr=0x0040_0010 that cycle; next cycle Status=0x0F.
4. mtc0 rd=12 wdata=32'h1 (syscall masked), exception cause=8 -> Status, Cause, EPC unchanged. Same sequence with cause=13 and Status=32'h9 -> accepted, Cause=32'h34.
5. Same cycle: exception cause=9, eret, and mtc0 rd=14 wdata=0xDEAD -> EPC=pc, Status shifted left by 5, eret and mtc0 discarded.
6. (CP0_TIMER_EN) mtc0 Count=0, Compare=5, Status=32'h8001 -> Cause[15]=1 and timer_irq=1 six cycles after the Count write. mtc0 Compare=100 -> both return to 0 next cycle.

Source files
------------

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 for the multi-cycle MIPS core: Status/Cause/EPC with the 5-bit Status shift-stack.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  cause,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] exc_addr,
  output logic        timer_irq
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic mask_ok;
  logic accept;
  logic do_eret;

  always_comb begin
    case (cause)
      EXC_SYSCALL: mask_ok = status_q[1];
      EXC_BREAK:   mask_ok = status_q[2];
      EXC_TEQ:     mask_ok = status_q[3];
      default:     mask_ok = 1'b1;
    endcase
  end

  assign accept  = exception & status_q[0] & mask_ok;
  // Any exception request, accepted or not, suppresses a concurrent eret.
  assign do_eret = eret & ~exception;

  assign status   = status_q;
  assign exc_addr = do_eret ? epc_q : EXC_VECTOR;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    if (mtc0 && rd == REG_COUNT)   count_d   = wdata;
    if (mtc0 && rd == REG_COMPARE) compare_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign timer_irq = cause_q[15] & status_q[15] & status_q[0];
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (accept) begin
      status_d     = {status_q[26:0], 5'b0};
      cause_d[6:2] = cause;
      epc_d        = pc;
    end else begin
      if (do_eret)
        status_d = {5'b0, status_q[31:5]};
      else if (mtc0 && rd == REG_STATUS)
        status_d = wdata;
      if (mtc0 && rd == REG_CAUSE) cause_d[9:8] = wdata[9:8];
      if (mtc0 && rd == REG_EPC)   epc_d = wdata;
    end
`ifdef CP0_TIMER_EN
    // Pending timer bit is sticky; a Compare write in the same cycle clears it.
    if (count_q == compare_q && compare_q != 32'h0) cause_d[15] = 1'b1;
    if (mtc0 && rd == REG_COMPARE) cause_d[15] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= STATUS_RESET;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (mfc0) begin
      case (rd)
        REG_STATUS:  rdata = status_q;
        REG_CAUSE:   rdata = cause_q;
        REG_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
        REG_COUNT:   rdata = count_q;
        REG_COMPARE: rdata = compare_q;
`endif
        default:     rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: expected values are queued as stimulus is driven
// and popped when the matching DUT output is sampled on the falling edge.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mfc0, mtc0, exception, eret;
  logic [31:0] pc, wdata;
  logic [4:0]  rd, cause;
  logic [31:0] rdata, status, exc_addr;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  cp0_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mfc0      (mfc0),
    .mtc0      (mtc0),
    .pc        (pc),
    .rd        (rd),
    .wdata     (wdata),
    .exception (exception),
    .eret      (eret),
    .cause     (cause),
    .rdata     (rdata),
    .status    (status),
    .exc_addr  (exc_addr),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic idle();
    mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
    rd = 0; wdata = 0; pc = 0; cause = 0;
  endtask

  task automatic expect_push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic expect_pop(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, obs, e);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic read_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    mfc0 = 1; rd = idx;
    expect_push(tag, exp);
    @(negedge clk);
    expect_pop(rdata);
    finish_cycle();
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    mtc0 = 1; rd = idx; wdata = data;
    finish_cycle();
  endtask

  task automatic raise_exc(input string tag, input logic [4:0] code, input logic [31:0] ret_pc);
    exception = 1; cause = code; pc = ret_pc;
    expect_push(tag, 32'h0000_0004);
    @(negedge clk);
    expect_pop(exc_addr);
    finish_cycle();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // Reset state
    expect_push("rst_status_port", 32'h0000_000F);
    @(negedge clk);
    expect_pop(status);
    read_reg("rst_status", 5'd12, 32'h0000_000F);
    read_reg("rst_cause", 5'd13, 32'h0);
    read_reg("rst_epc", 5'd14, 32'h0);
    expect_push("rst_timer_irq", 32'h0);
    expect_pop({31'b0, timer_irq});

    // Syscall accepted from reset Status
    raise_exc("sys_exc_addr", 5'd8, 32'h0040_0010);
    read_reg("sys_epc", 5'd14, 32'h0040_0010);
    read_reg("sys_cause", 5'd13, 32'h0000_0020);
    read_reg("sys_status", 5'd12, 32'h0000_01E0);

    // eret returns to EPC and pops Status
    eret = 1;
    expect_push("eret_exc_addr", 32'h0040_0010);
    @(negedge clk);
    expect_pop(exc_addr);
    finish_cycle();
    read_reg("eret_status", 5'd12, 32'h0000_000F);

    // Syscall masked: no state change
    write_reg(5'd12, 32'h1);
    raise_exc("masked_exc_addr", 5'd8, 32'h0000_0123);
    read_reg("masked_status", 5'd12, 32'h0000_0001);
    read_reg("masked_cause", 5'd13, 32'h0000_0020);
    read_reg("masked_epc", 5'd14, 32'h0040_0010);

    // teq accepted with its mask bit set
    write_reg(5'd12, 32'h9);
    raise_exc("teq_exc_addr", 5'd13, 32'h0040_0020);
    read_reg("teq_cause", 5'd13, 32'h0000_0034);
    read_reg("teq_epc", 5'd14, 32'h0040_0020);
    read_reg("teq_status", 5'd12, 32'h0000_0120);

    // break + eret + mtc0 EPC together: exception wins
    write_reg(5'd12, 32'h5);
    exception = 1; cause = 5'd9; pc = 32'h0040_0030;
    eret = 1; mtc0 = 1; rd = 5'd14; wdata = 32'h0000_DEAD;
    expect_push("coll_exc_addr", 32'h0000_0004);
    @(negedge clk);
    expect_pop(exc_addr);
    finish_cycle();
    read_reg("coll_epc", 5'd14, 32'h0040_0030);
    read_reg("coll_status", 5'd12, 32'h0000_00A0);
    read_reg("coll_cause", 5'd13, 32'h0000_0024);

    // Only Cause[9:8] is software writable
    write_reg(5'd13, 32'hFFFF_FFFF);
    read_reg("cause_ip_write", 5'd13, 32'h0000_0324);

    // eret beats mtc0 to Status
    eret = 1; mtc0 = 1; rd = 5'd12; wdata = 32'h0000_FFFF;
    finish_cycle();
    read_reg("eret_vs_mtc0", 5'd12, 32'h0000_0005);

    // Unimplemented index ignores writes and reads zero
    write_reg(5'd20, 32'h1234_5678);
    read_reg("unimpl_reg", 5'd20, 32'h0);

    // mfc0 does not see a same-cycle mtc0
    mfc0 = 1; mtc0 = 1; rd = 5'd14; wdata = 32'h0000_0077;
    expect_push("no_forward", 32'h0040_0030);
    @(negedge clk);
    expect_pop(rdata);
    finish_cycle();
    read_reg("epc_written", 5'd14, 32'h0000_0077);

    // Reset overrides a concurrent exception
    reset = 1; exception = 1; cause = 5'd8; pc = 32'h0000_0999;
    finish_cycle();
    reset = 0;
    read_reg("rst_mid_status", 5'd12, 32'h0000_000F);
    read_reg("rst_mid_epc", 5'd14, 32'h0);
    read_reg("rst_mid_cause", 5'd13, 32'h0);

`ifdef CP0_TIMER_EN
    write_reg(5'd9, 32'h0000_1000);
    read_reg("count_load", 5'd9, 32'h0000_1000);

    // Count written at edge E0; Count==Compare after E5, pending bit set at E6
    write_reg(5'd9, 32'h0);
    write_reg(5'd11, 32'h5);
    write_reg(5'd12, 32'h0000_8001);
    repeat (3) finish_cycle();
    expect_push("irq_before_match", 32'h0);
    expect_pop({31'b0, timer_irq});
    finish_cycle();
    expect_push("irq_at_match", 32'h1);
    expect_pop({31'b0, timer_irq});
    read_reg("cause_timer_set", 5'd13, 32'h0000_8000);

    write_reg(5'd11, 32'd100);
    expect_push("irq_cleared", 32'h0);
    expect_pop({31'b0, timer_irq});
    read_reg("cause_timer_clr", 5'd13, 32'h0);

    write_reg(5'd9, 32'hFFFF_FFFF);
    finish_cycle();
    read_reg("count_wrap", 5'd9, 32'h0);
`else
    write_reg(5'd9, 32'h0000_1000);
    read_reg("count_absent", 5'd9, 32'h0);
    write_reg(5'd11, 32'h5);
    read_reg("compare_absent", 5'd11, 32'h0);
    write_reg(5'd12, 32'h0000_8001);
    repeat (8) finish_cycle();
    expect_push("no_timer_irq", 32'h0);
    expect_pop({31'b0, timer_irq});
    read_reg("no_timer_cause", 5'd13, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
